// File: rtl/cpu_mul_pipe.sv
// ---------------------------------------------------------------------------
// cpu_mul_pipe
//
// Purpose:
//   Pipelined integer multiplier with per-operand signedness selection,
//   a sideband tag that travels with each operation, valid/ready flow
//   control on both sides, a global clock enable and a synchronous flush.
//   Latency is NUM_STAGE cycles; one result per cycle when not stalled.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous, active-high; clears all valids, dout, out_tag
//   ce           in   global clock enable; while low nothing changes
//   flush        in   synchronous kill of every in-flight operation (needs ce)
//   in_valid     in   operands present
//   in_ready     out  operation accepted when in_valid & in_ready
//   din0, din1   in   operands
//   din0_signed  in   1 = din0 is two's complement, 0 = unsigned
//   din1_signed  in   1 = din1 is two's complement, 0 = unsigned
//   in_tag       in   sideband tag accompanying the operands
//   out_valid    out  result present
//   out_ready    in   consumer accepts the result
//   dout         out  product (truncated or sign-extended to DOUT_WIDTH)
//   out_tag      out  tag belonging to the result on dout
// ---------------------------------------------------------------------------
module cpu_mul_pipe #(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 32,
    parameter int DOUT_WIDTH = 64,
    parameter int NUM_STAGE  = 2,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    // Operands are widened to a common width strictly larger than both
    // inputs and the output. Multiplication modulo 2^EXT_WIDTH of the
    // widened bit patterns gives the exact signed product modulo that
    // power of two, so its low DOUT_WIDTH bits are the true product
    // either truncated or sign-extended as needed.
    localparam int MAX_IN    = (DIN0_WIDTH > DIN1_WIDTH) ? DIN0_WIDTH : DIN1_WIDTH;
    localparam int EXT_WIDTH = ((MAX_IN > DOUT_WIDTH) ? MAX_IN : DOUT_WIDTH) + 1;

    logic [EXT_WIDTH-1:0]  w_op0Ext;
    logic [EXT_WIDTH-1:0]  w_op1Ext;
    logic [DOUT_WIDTH-1:0] w_product;
    logic                  w_advance;

    logic                  r_valid [NUM_STAGE];
    logic [DOUT_WIDTH-1:0] r_data  [NUM_STAGE];
    logic [TAG_WIDTH-1:0]  r_tag   [NUM_STAGE];

    // Sign bit replicated only when the operand is declared signed.
    assign w_op0Ext  = {{(EXT_WIDTH-DIN0_WIDTH){din0_signed & din0[DIN0_WIDTH-1]}}, din0};
    assign w_op1Ext  = {{(EXT_WIDTH-DIN1_WIDTH){din1_signed & din1[DIN1_WIDTH-1]}}, din1};
    assign w_product = DOUT_WIDTH'(w_op0Ext * w_op1Ext);

    // The whole pipe moves as one unit: it may shift whenever the output
    // slot is empty or being drained this cycle.
    assign w_advance = ce & (~r_valid[NUM_STAGE-1] | out_ready);
    assign in_ready  = w_advance;

    assign out_valid = r_valid[NUM_STAGE-1];
    assign dout      = r_data[NUM_STAGE-1];
    assign out_tag   = r_tag[NUM_STAGE-1];

    // Stage registers. Flush beats advance and also drops the input
    // presented in the same cycle; a stall holds every register as is.
    // Bubbles still capture the (meaningless) product to keep the data
    // path free of enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= '0;
                r_tag[i]   <= '0;
            end
        end else if (ce && flush) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_advance) begin
            r_valid[0] <= in_valid;
            r_data[0]  <= w_product;
            r_tag[0]   <= in_tag;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_cpu_mul_pipe
//
// Purpose:
//   Directed bench for cpu_mul_pipe. A default-parameter instance is
//   driven through latency, signedness, stall, flush, clock-enable and
//   reset scenarios; every accepted operation pushes its expected product
//   and tag to a queue that a monitor drains whenever a result is taken.
//   A second small instance (one stage, 8x8->16) covers the narrow case.
// ---------------------------------------------------------------------------
module tb_cpu_mul_pipe;

    typedef struct {
        logic [63:0] prod;
        logic [4:0]  tag;
    } sbEntry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        din0Signed;
    logic        din1Signed;
    logic [4:0]  inTag;
    logic        outValid;
    logic        outReady;
    logic [63:0] dout;
    logic [4:0]  outTag;

    logic        sInValid;
    logic        sInReady;
    logic [7:0]  sDin0;
    logic [7:0]  sDin1;
    logic        sDin0Signed;
    logic        sDin1Signed;
    logic [4:0]  sInTag;
    logic        sOutValid;
    logic [15:0] sDout;
    logic [4:0]  sOutTag;

    sbEntry_t    sb[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] expHold;

    // 10 ns clock.
    always #5 clk = ~clk;

    cpu_mul_pipe u_dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .flush       (flush),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .din0        (din0),
        .din1        (din1),
        .din0_signed (din0Signed),
        .din1_signed (din1Signed),
        .in_tag      (inTag),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .dout        (dout),
        .out_tag     (outTag)
    );

    cpu_mul_pipe #(
        .DIN0_WIDTH (8),
        .DIN1_WIDTH (8),
        .DOUT_WIDTH (16),
        .NUM_STAGE  (1),
        .TAG_WIDTH  (5)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .flush       (flush),
        .in_valid    (sInValid),
        .in_ready    (sInReady),
        .din0        (sDin0),
        .din1        (sDin1),
        .din0_signed (sDin0Signed),
        .din1_signed (sDin1Signed),
        .in_tag      (sInTag),
        .out_valid   (sOutValid),
        .out_ready   (1'b1),
        .dout        (sDout),
        .out_tag     (sOutTag)
    );

    // Reference product: exact signed multiply of the 33-bit extended
    // operands in a 66-bit signed accumulator, then keep the low 64 bits.
    function automatic logic [63:0] model64(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb2);
        logic signed [32:0] x;
        logic signed [32:0] y;
        logic signed [65:0] p;
        x = {sa & a[31], a};
        y = {sb2 & b[31], b};
        p = 66'(x) * 66'(y);
        return p[63:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and holds it until accepted (bounded wait).
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic sa, input logic sb2, input logic [4:0] tag);
        logic accepted;
        sbEntry_t e;
        din0       = a;
        din1       = b;
        din0Signed = sa;
        din1Signed = sb2;
        inTag      = tag;
        inValid    = 1'b1;
        accepted   = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (inReady) begin
                accepted = 1'b1;
                e.prod   = model64(a, b, sa, sb2);
                e.tag    = tag;
                sb.push_back(e);
            end
            tick();
        end
        inValid = 1'b0;
        checkOutput("accept", 64'(accepted), 64'd1);
    endtask

    // Scoreboard monitor: every result transfer is compared in order.
    always @(negedge clk) begin
        sbEntry_t e;
        if (!reset && ce && !flush && outValid && outReady) begin
            checkOutput("sb nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("sb dout", dout, e.prod);
                checkOutput("sb tag", 64'(outTag), 64'(e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset       = 1'b1;
        ce          = 1'b1;
        flush       = 1'b0;
        inValid     = 1'b0;
        outReady    = 1'b1;
        din0        = '0;
        din1        = '0;
        din0Signed  = 1'b0;
        din1Signed  = 1'b0;
        inTag       = '0;
        sInValid    = 1'b0;
        sDin0       = '0;
        sDin1       = '0;
        sDin0Signed = 1'b0;
        sDin1Signed = 1'b0;
        sInTag      = '0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset out_valid", 64'(outValid), 64'd0);
        checkOutput("reset dout", dout, 64'd0);
        checkOutput("reset out_tag", 64'(outTag), 64'd0);
        checkOutput("reset in_ready", 64'(inReady), 64'd1);
        tick();
        reset = 1'b0;

        // First op right after reset release, both signed, latency 2
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd3);
        @(negedge clk);
        checkOutput("lat1 out_valid", 64'(outValid), 64'd0);
        @(negedge clk);
        checkOutput("lat2 out_valid", 64'(outValid), 64'd1);
        checkOutput("lat2 dout", dout, 64'h0000_0000_0000_0001);
        checkOutput("lat2 out_tag", 64'(outTag), 64'd3);
        tick();

        // Unsigned and mixed signedness
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd4);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd5);
        @(negedge clk);
        checkOutput("unsigned dout", dout, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        checkOutput("mixed dout", dout, 64'hFFFF_FFFF_0000_0001);
        tick();
        tick();

        // Narrow single-stage instance
        sDin0 = 8'h80; sDin1 = 8'h80; sDin0Signed = 1'b1; sDin1Signed = 1'b1; sInTag = 5'd9;
        sInValid = 1'b1;
        @(negedge clk);
        checkOutput("small in_ready", 64'(sInReady), 64'd1);
        tick();
        sInValid = 1'b0;
        @(negedge clk);
        checkOutput("small out_valid", 64'(sOutValid), 64'd1);
        checkOutput("small dout", 64'(sDout), 64'h4000);
        checkOutput("small out_tag", 64'(sOutTag), 64'd9);
        tick();
        sDin0 = 8'hFF; sDin1 = 8'hFF; sDin0Signed = 1'b0; sDin1Signed = 1'b0;
        sInValid = 1'b1;
        tick();
        sInValid = 1'b0;
        @(negedge clk);
        checkOutput("small unsigned dout", 64'(sDout), 64'hFE01);
        tick();
        @(negedge clk);
        checkOutput("small bubble", 64'(sOutValid), 64'd0);
        tick();

        // Back-to-back with a 3-cycle consumer stall at the first result
        expHold = model64(32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0);
        applyStimulus(32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 5'd0);
        applyStimulus(32'h8000_0000, 32'h0000_0003, 1'b1, 1'b0, 5'd1);
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din0 = 32'h7FFF_FFFF; din1 = 32'h8000_0001; din0Signed = 1'b1; din1Signed = 1'b1;
            inTag = 5'd2; inValid = 1'b1;
            @(negedge clk);
            checkOutput("stall in_ready", 64'(inReady), 64'd0);
            checkOutput("stall out_valid", 64'(outValid), 64'd1);
            checkOutput("stall out_tag", 64'(outTag), 64'd0);
            checkOutput("stall dout", dout, expHold);
            tick();
        end
        outReady = 1'b1;
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 1'b1, 5'd2);
        applyStimulus(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b1, 5'd3);
        for (int i = 0; i < 4; i++) tick();

        // Flush with two operations in flight
        outReady = 1'b0;
        applyStimulus(32'd7, 32'd9, 1'b0, 1'b0, 5'd20);
        applyStimulus(32'd11, 32'd13, 1'b0, 1'b0, 5'd21);
        flush = 1'b1;
        sb.delete();
        tick();
        flush = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("flush out_valid", 64'(outValid), 64'd0);
            tick();
        end
        applyStimulus(32'd100, 32'hFFFF_FFFE, 1'b0, 1'b1, 5'd22);
        @(negedge clk);
        checkOutput("post-flush lat1", 64'(outValid), 64'd0);
        @(negedge clk);
        checkOutput("post-flush lat2", 64'(outValid), 64'd1);
        checkOutput("post-flush dout", dout, 64'hFFFF_FFFF_FFFF_FF38);
        tick();
        tick();

        // Clock enable low: held result stays, empty pipe stays empty
        outReady = 1'b0;
        expHold = model64(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
        applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 5'd23);
        tick();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            outReady = (i % 2) == 0;
            @(negedge clk);
            checkOutput("ce0 held valid", 64'(outValid), 64'd1);
            checkOutput("ce0 held dout", dout, expHold);
            checkOutput("ce0 in_ready", 64'(inReady), 64'd0);
            tick();
        end
        ce = 1'b1;
        outReady = 1'b1;
        tick();
        tick();
        ce = 1'b0;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            outReady = (i % 2) == 1;
            @(negedge clk);
            checkOutput("ce0 empty valid", 64'(outValid), 64'd0);
            checkOutput("ce0 empty in_ready", 64'(inReady), 64'd0);
            tick();
        end
        inValid = 1'b0;
        ce = 1'b1;
        outReady = 1'b1;
        tick();

        // Reset mid-pipeline: outputs clear without a clock edge
        outReady = 1'b0;
        applyStimulus(32'd5, 32'd6, 1'b0, 1'b0, 5'd24);
        applyStimulus(32'd7, 32'd8, 1'b0, 1'b0, 5'd25);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async rst out_valid", 64'(outValid), 64'd0);
        checkOutput("async rst dout", dout, 64'd0);
        checkOutput("async rst out_tag", 64'(outTag), 64'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no stale result", 64'(outValid), 64'd0);
            tick();
        end

        // Mixed traffic through the scoreboard
        for (int k = 0; k < 6; k++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 5'(k + 8));
        end
        for (int i = 0; i < 5; i++) tick();
        checkOutput("sb drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
